alu_datapath_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle register-bank/ALU datapath.
- Holds NREGS registers of DATA_W bits, a flag register and a 3-stage issue/execute/writeback pipeline with a valid/ready issue handshake and hazard interlock.
- The global FSM/decoder drives the issue port; results and flags feed branch logic and the load/store path.

---
 rtl/alu_dp_pkg.sv | 39 +++
 rtl/alu_dp_core.sv | 54 +++++
 rtl/alu_datapath_pipe.sv | 114 +++++++++++
 tb/tb_alu_datapath_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_dp_pkg.sv
// Shared types and constants for the pipelined ALU datapath: opcode encodings,
// flag bit positions and opcode classification helpers.
package alu_dp_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpAddc = 4'd1,
    OpSub  = 4'd2,
    OpSubc = 4'd3,
    OpCmp  = 4'd4,
    OpAnd  = 4'd5,
    OpOr   = 4'd6,
    OpXor  = 4'd7,
    OpMov  = 4'd8,
    OpLsh  = 4'd9,
    OpArsh = 4'd10
  } op_e;

  localparam int unsigned FLAG_W = 5;
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  function automatic int unsigned shamt_w(input int unsigned data_w);
    return $clog2(data_w);
  endfunction

  // Codes above OpArsh are NOPs: no flags, no writeback.
  function automatic logic op_sets_flags(input logic [3:0] op);
    return op <= OpArsh;
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OpArsh) && (op != OpCmp);
  endfunction

endpackage

// File: rtl/alu_dp_core.sv
// Combinational ALU: computes the result and the full next-flag vector for one op.
module alu_dp_core import alu_dp_pkg::*; #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags_next
);

  localparam int unsigned SHW = shamt_w(DATA_W);
  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic [SHW-1:0]  shamt;
  logic            is_add;

  always_comb begin
    shamt  = b[SHW-1:0];
    is_add = (op == OpAdd) || (op == OpAddc);
    sum    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, (op == OpAddc) & c_in};
    diff   = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, (op == OpSubc) & c_in};

    result = '0;
    case (op)
      OpAdd, OpAddc:        result = sum[DATA_W-1:0];
      OpSub, OpSubc, OpCmp: result = diff[DATA_W-1:0];
      OpAnd:                result = a & b;
      OpOr:                 result = a | b;
      OpXor:                result = a ^ b;
      OpMov:                result = b;
      OpLsh:                result = a << shamt;
      OpArsh:               result = $signed(a) >>> shamt;
      default:              result = '0;
    endcase

    flags_next         = '0;
    flags_next[FLAG_Z] = (result == '0);
    if (op <= OpCmp) begin
      flags_next[FLAG_C] = is_add ? sum[DATA_W] : diff[DATA_W];
      flags_next[FLAG_L] = a < b;
      flags_next[FLAG_N] = $signed(a) < $signed(b);
      // Overflow: add with like-signed operands, or sub with unlike-signed, flips the sign.
      flags_next[FLAG_F] = is_add ? ((a[MSB] == b[MSB]) && (result[MSB] != a[MSB]))
                                  : ((a[MSB] != b[MSB]) && (result[MSB] != a[MSB]));
    end else begin
      flags_next[FLAG_N] = result[MSB];
    end
  end

endmodule

// File: rtl/alu_datapath_pipe.sv
// Register bank, flag register and issue/execute/writeback pipeline around alu_dp_core.
// Define ALU_DP_FWD_EN to bypass the WB-stage result into operand read.
module alu_datapath_pipe import alu_dp_pkg::*; #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned IMM_W  = 8,
  localparam int unsigned REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [REG_AW-1:0] op_rdst,
  input  logic [REG_AW-1:0] op_rsrc,
  input  logic [IMM_W-1:0]  op_imm,
  input  logic              op_imm_sel,
  input  logic              op_imm_sext,
  input  logic              op_flag_we,
  input  logic              op_wb_en,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_rdst,
  output logic [FLAG_W-1:0] flags,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [FLAG_W-1:0] flags_q;

  logic [3:0]        ex_op_q;
  logic [DATA_W-1:0] ex_a_q, ex_b_q;
  logic [REG_AW-1:0] ex_rdst_q;
  logic              ex_wr_q, ex_flag_we_q;

  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [REG_AW-1:0] wb_rdst_q;

  logic [DATA_W-1:0] imm_ext, a_rd, b_rd, alu_result;
  logic [FLAG_W-1:0] alu_flags;
  logic              hit_ex, hit_wb, hazard, issue;

  always_comb begin
    imm_ext = op_imm_sext ? {{(DATA_W-IMM_W){op_imm[IMM_W-1]}}, op_imm}
                          : {{(DATA_W-IMM_W){1'b0}}, op_imm};
    a_rd    = regs_q[op_rdst];
    b_rd    = regs_q[op_rsrc];
`ifdef ALU_DP_FWD_EN
    if (wb_valid_q && (wb_rdst_q == op_rdst)) a_rd = wb_data_q;
    if (wb_valid_q && (wb_rdst_q == op_rsrc)) b_rd = wb_data_q;
`endif
    if (op_imm_sel) b_rd = imm_ext;

    hit_ex = ex_wr_q && ((ex_rdst_q == op_rdst) || (!op_imm_sel && (ex_rdst_q == op_rsrc)));
    hit_wb = wb_valid_q && ((wb_rdst_q == op_rdst) || (!op_imm_sel && (wb_rdst_q == op_rsrc)));
`ifdef ALU_DP_FWD_EN
    hazard = hit_ex;
`else
    hazard = hit_ex || hit_wb;
`endif
    op_ready = !reset && !hazard;
    issue    = op_valid && op_ready;
  end

  alu_dp_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .a          (ex_a_q),
    .b          (ex_b_q),
    .op         (ex_op_q),
    .c_in       (flags_q[FLAG_C]),
    .result     (alu_result),
    .flags_next (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q       <= '{default: '0};
      flags_q      <= '0;
      ex_op_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_rdst_q    <= '0;
      ex_wr_q      <= 1'b0;
      ex_flag_we_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rdst_q    <= '0;
    end else begin
      ex_wr_q      <= issue && op_wb_en && op_writes(op_code);
      ex_flag_we_q <= issue && op_flag_we && op_sets_flags(op_code);
      if (issue) begin
        ex_op_q   <= op_code;
        ex_a_q    <= a_rd;
        ex_b_q    <= b_rd;
        ex_rdst_q <= op_rdst;
      end
      wb_valid_q <= ex_wr_q;
      wb_data_q  <= alu_result;
      wb_rdst_q  <= ex_rdst_q;
      if (ex_flag_we_q) flags_q <= alu_flags;
      if (wb_valid_q) regs_q[wb_rdst_q] <= wb_data_q;
    end
  end

  assign res_valid = wb_valid_q;
  assign res_data  = wb_data_q;
  assign res_rdst  = wb_rdst_q;
  assign flags     = flags_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_datapath_pipe.sv
// Scoreboard bench for alu_datapath_pipe: expected results queued at issue, checked at WB.
module tb_alu_datapath_pipe;
  import alu_dp_pkg::*;

`ifdef ALU_DP_FWD_EN
  localparam int DIST1_STALL = 1;
`else
  localparam int DIST1_STALL = 2;
`endif

  logic        clk, reset, op_valid, op_ready;
  logic [3:0]  op_code, op_rdst, op_rsrc, res_rdst, dbg_addr;
  logic [7:0]  op_imm;
  logic        op_imm_sel, op_imm_sext, op_flag_we, op_wb_en, res_valid;
  logic [15:0] res_data, dbg_data;
  logic [4:0]  flags;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  rdst;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_stalls = 0;

  alu_datapath_pipe #(
    .DATA_W (16),
    .NREGS  (16),
    .IMM_W  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .op_rdst     (op_rdst),
    .op_rsrc     (op_rsrc),
    .op_imm      (op_imm),
    .op_imm_sel  (op_imm_sel),
    .op_imm_sext (op_imm_sext),
    .op_flag_we  (op_flag_we),
    .op_wb_en    (op_wb_en),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_rdst    (res_rdst),
    .flags       (flags),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_res_valid", {31'b0, res_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("res_data", {16'b0, res_data}, {16'b0, e.data});
        check_eq("res_rdst", {28'b0, res_rdst}, {28'b0, e.rdst});
        check_eq("res_latency", cyc - e.cyc, 32'd2);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the issue edge.
  task automatic issue(input logic [3:0] code, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [7:0] imm, input logic isel, input logic sext,
                       input logic fwe, input logic wbe, input logic exp_wr,
                       input logic [15:0] exp_data);
    exp_t e;
    int   st = 0;
    op_valid = 1'b1; op_code = code; op_rdst = rd; op_rsrc = rs; op_imm = imm;
    op_imm_sel = isel; op_imm_sext = sext; op_flag_we = fwe; op_wb_en = wbe;
    #1;
    while (!op_ready && st < 10) begin
      @(negedge clk);
      #1;
      st++;
    end
    last_stalls = st;
    if (!op_ready) begin
      check_eq("issue_timeout", {31'b0, op_ready}, 32'd1);
      op_valid = 1'b0;
      return;
    end
    if (exp_wr) begin
      e.data = exp_data; e.rdst = rd; e.cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic dbg_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    check_eq(tag, {16'b0, dbg_data}, {16'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_rdst = '0; op_rsrc = '0; op_imm = '0;
    op_imm_sel = 1'b0; op_imm_sext = 1'b0; op_flag_we = 1'b0; op_wb_en = 1'b0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'b0, op_ready}, 32'd0);
    check_eq("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check_eq("rst_flags", {27'b0, flags}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MOV, MOV, dependent ADD
    issue(OpMov, 1, 0, 8'h05, 1, 0, 0, 1, 1, 16'h0005);
    issue(OpMov, 2, 0, 8'h03, 1, 0, 0, 1, 1, 16'h0003);
    check_eq("mov_b2b_stall", last_stalls, 32'd0);
    issue(OpAdd, 1, 2, 8'h00, 0, 0, 0, 1, 1, 16'h0008);
    check_eq("add_dep_stall", last_stalls, DIST1_STALL);
    idle(3);
    dbg_chk("dbg_r1", 1, 16'h0008);
    dbg_chk("dbg_r2", 2, 16'h0003);

    // carry chain: ADD sets C, ADDC consumes it back-to-back
    issue(OpMov, 3, 0, 8'hFF, 1, 1, 0, 1, 1, 16'hFFFF);
    issue(OpAdd, 3, 0, 8'h01, 1, 0, 1, 1, 1, 16'h0000);
    issue(OpAddc, 4, 0, 8'h00, 1, 0, 0, 1, 1, 16'h0001);
    check_eq("add_flags", {27'b0, flags}, 32'b11001);
    idle(3);
    dbg_chk("dbg_r3", 3, 16'h0000);
    dbg_chk("dbg_r4", 4, 16'h0001);

    // CMP with wb_en set must not write
    issue(OpMov, 5, 0, 8'h01, 1, 0, 0, 1, 1, 16'h0001);
    issue(OpMov, 6, 0, 8'h01, 1, 0, 0, 1, 1, 16'h0001);
    issue(OpLsh, 5, 0, 8'h0F, 1, 0, 0, 1, 1, 16'h8000);
    issue(OpCmp, 5, 6, 8'h00, 0, 0, 1, 1, 0, 16'h0000);
    idle(3);
    check_eq("cmp_flags", {27'b0, flags}, 32'b10100);
    dbg_chk("dbg_r5", 5, 16'h8000);

    // immediate sign/zero extension
    issue(OpSub, 7, 0, 8'hFF, 1, 1, 0, 1, 1, 16'h0001);
    issue(OpMov, 7, 0, 8'h00, 1, 0, 0, 1, 1, 16'h0000);
    issue(OpSub, 7, 0, 8'hFF, 1, 0, 0, 1, 1, 16'hFF01);
    idle(3);
    dbg_chk("dbg_r7", 7, 16'hFF01);

    // shifts and a NOP opcode
    issue(OpMov, 8, 0, 8'h01, 1, 0, 0, 1, 1, 16'h0001);
    issue(OpLsh, 8, 0, 8'h0F, 1, 0, 0, 1, 1, 16'h8000);
    issue(OpArsh, 8, 0, 8'h04, 1, 0, 0, 1, 1, 16'hF800);
    issue(OpMov, 9, 0, 8'h01, 1, 0, 0, 1, 1, 16'h0001);
    issue(OpLsh, 9, 0, 8'h13, 1, 0, 0, 1, 1, 16'h0008);
    issue(4'd12, 9, 0, 8'h55, 1, 0, 1, 1, 0, 16'h0000);
    idle(3);
    check_eq("nop_flags", {27'b0, flags}, 32'b10100);
    dbg_chk("dbg_r8", 8, 16'hF800);
    dbg_chk("dbg_r9", 9, 16'h0008);

    // logic ops; OR updates flags from a nonzero result
    issue(OpXor, 9, 0, 8'h0C, 1, 0, 0, 1, 1, 16'h0004);
    issue(OpAnd, 9, 0, 8'h06, 1, 0, 0, 1, 1, 16'h0004);
    issue(OpOr, 9, 0, 8'h01, 1, 0, 1, 1, 1, 16'h0005);
    idle(3);
    check_eq("or_flags", {27'b0, flags}, 32'd0);
    dbg_chk("dbg_r9_logic", 9, 16'h0005);

    // reset while an ADD is in EX
    issue(OpCmp, 5, 6, 8'h00, 0, 0, 1, 0, 0, 16'h0000);
    idle(1);
    issue(OpAdd, 10, 0, 8'h05, 1, 0, 1, 1, 0, 16'h0000);
    reset = 1'b1;
    #1;
    check_eq("ready_in_reset", {31'b0, op_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_res_valid", {31'b0, res_valid}, 32'd0);
    check_eq("post_rst_flags", {27'b0, flags}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_chk("post_rst_reg", 4'(i), 16'h0000);
    end
    idle(3);
    dbg_chk("dropped_add_r10", 10, 16'h0000);
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
